swap_ctrl: RTL and testbench
============================

# swap_ctrl

Sequencing front-end for the three-register swap datapath. It accepts three operands on a valid/ready input stream and loads them into R1, R2 and R3 through the datapath's `Data` bus and external load strobes. It then pulses the swap request and waits for `Done`. Finally it streams the swapped register contents R1, R2, R3 out on a valid/ready output stream. It sits directly upstream of the swap datapath, drives all of that block's control inputs, and also consumes its register outputs.

## Interface
- `n`, 8: operand / register width.
- `TIMEOUT`, 15: maximum cycles in WAIT before error (used only with the timeout macro).
- `CW`, 4: width of the timeout counter; must satisfy 2^CW > TIMEOUT.

Ports:
- `Clock`, in, 1: single clock, rising edge.
- `Resetn`, in, 1: reset, synchronous, active-low.
- `InData`, in, n: operand from the host.
- `InValid`, in, 1: `InData` is valid.
- `InReady`, out, 1: block accepts an operand this cycle.
- `Data`, out, n: to datapath `Data`.
- `RinExt1`, `RinExt2`, `RinExt3`, out, 1 each: to datapath external load strobes.
- `w`, out, 1: swap request to the datapath.
- `Done`, in, 1: datapath completion flag.
- `R1`, `R2`, `R3`, in, n each: datapath register outputs.
- `OutData`, out, n: result word.
- `OutValid`, out, 1: `OutData` is valid.
- `OutReady`, in, 1: downstream accepts.
- `SwapCount`, out, 8: number of completed swaps, wraps 255→0.
- `Error`, out, 1: Done-timeout flag, sticky.

## Operation
- FSM states: LOAD1, LOAD2, LOAD3, GO, WAIT, OUT1, OUT2, OUT3, ERR.
- LOADk (k = 1..3):
  - `InReady` = 1 and `Data` = `InData`.
  - `RinExtk` = `InValid`; the other strobes are 0.
  - On `InValid` = 1, advance to the next state (LOAD3 → GO). Otherwise hold.
- GO: `w` = 1 for exactly one cycle, `Data` = 0, all strobes 0. Advance to WAIT unconditionally.
- WAIT: `w` = 0. On `Done` = 1, go to OUT1 and increment `SwapCount`. Otherwise hold.
- OUTk:
  - `OutValid` = 1; `OutData` = R1, R2 or R3 respectively.
  - On `OutReady` = 1, advance (OUT3 → LOAD1). Otherwise hold with `OutData` stable.
- Result for loaded operands a, b, c is R1 = b, R2 = a, R3 = b. Output order is b, a, b.
- All outputs not listed for a state are 0 in that state.
- `InReady` is 1 only in LOADk. `OutValid` is 1 only in OUTk. No operand is accepted while results are pending.
- `Data`, `RinExtk`, `InReady`, `w`, `OutValid` and `OutData` are decoded combinationally from the state register and inputs.
- `SwapCount` and `Error` are registered.

## Timing
- Reset: synchronous. While `Resetn` = 0 at a rising edge, the following hold on the next cycle:
  - state = LOAD1, `SwapCount` = 0, `Error` = 0, timeout counter = 0.
  - All other outputs follow the LOAD1 decode: `InReady` = 1, `w` = 0, `OutValid` = 0.
- Reset mid-operation, in any state, abandons the transaction. No partial outputs are replayed.
- Operand load: an operand accepted in cycle t is written into Rk at the edge ending cycle t.
- Swap latency:
  - `w` is high in cycle t.
  - `Done` is seen in WAIT at cycle t+3.
  - OUT1 is entered at t+4, when R1 already holds its new value.
- Minimum transaction: 3 load cycles + 1 GO + 3 WAIT + 3 output cycles = 10 cycles with no backpressure.
- `Done` seen in the same cycle as the timeout limit: `Done` wins; go to OUT1 with no error.

## Configuration
- `SWAP_CTRL_TIMEOUT_EN` defined:
  - The timeout counter clears on entry to WAIT and increments each WAIT cycle without `Done`.
  - When the counter equals `TIMEOUT`, the FSM goes to ERR.
  - ERR sets `Error` = 1, forces `InReady` = `OutValid` = `w` = 0, and is left only by reset.
- Not defined:
  - WAIT holds indefinitely.
  - `Error` is tied to 0, and neither the counter nor the ERR state is built.

## Test plan
- Reset: hold `Resetn` = 0 for 2 edges, then release. Required: `InReady` = 1, `OutValid` = 0, `w` = 0, `SwapCount` = 0, `Error` = 0.
- Basic swap: feed 0x11, 0x22, 0x33 with `OutReady` = 1.
  - `w` pulses for 1 cycle.
  - Output stream is 0x22, 0x11, 0x22.
  - `SwapCount` = 1; total of 10 cycles from the first acceptance.
- Input gaps: drop `InValid` for 2 cycles between each operand. Required: no strobe while `InValid` = 0, same results as the basic swap.
- Output backpressure: hold `OutReady` = 0 for 5 cycles in OUT2. Required: `OutData` stays stable at 0x11, and no new operand is accepted.
- Reset mid-WAIT: assert `Resetn` = 0 one cycle after GO. Required: the next cycle shows LOAD1 decode and `SwapCount` unchanged from 0.
- Timeout (macro on, `Done` forced 0): after GO, `Error` rises exactly `TIMEOUT` + 1 cycles later, all handshakes stay 0, and only reset clears it.
- Counter wrap: 256 back-to-back swaps. Required: `SwapCount` returns to 0.

Source files
------------

// File: rtl/swap_ctrl_if.sv
// Bundled handshake and datapath-control signals for swap_ctrl.
// master = the sequencer side; slave = host, downstream consumer and swap datapath.
interface swap_ctrl_if #(
   parameter int unsigned n = 8
);
   logic [n-1:0] InData;
   logic         InValid;
   logic         InReady;
   logic [n-1:0] Data;
   logic         RinExt1;
   logic         RinExt2;
   logic         RinExt3;
   logic         w;
   logic         Done;
   logic [n-1:0] R1;
   logic [n-1:0] R2;
   logic [n-1:0] R3;
   logic [n-1:0] OutData;
   logic         OutValid;
   logic         OutReady;
   logic [7:0]   SwapCount;
   logic         Error;

   modport master (
      input  InData, InValid, Done, R1, R2, R3, OutReady,
      output InReady, Data, RinExt1, RinExt2, RinExt3, w,
             OutData, OutValid, SwapCount, Error
   );

   modport slave (
      output InData, InValid, Done, R1, R2, R3, OutReady,
      input  InReady, Data, RinExt1, RinExt2, RinExt3, w,
             OutData, OutValid, SwapCount, Error
   );
endinterface

// File: rtl/swap_ctrl.sv
// Sequencer for the three-register swap datapath: load R1..R3, request swap, stream results.
// Optional Done-timeout with sticky Error is built when SWAP_CTRL_TIMEOUT_EN is defined.
module swap_ctrl #(
   parameter int unsigned n       = 8,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CW      = 4
) (
   input logic         Clock,
   input logic         Resetn,
   swap_ctrl_if.master bus
);
   localparam int unsigned CNT_W = 8;

   if ((1 << CW) <= TIMEOUT) begin : g_cw_check
      $error("swap_ctrl: 2**CW must exceed TIMEOUT");
   end

   typedef enum logic [3:0] {
      S_LOAD1, S_LOAD2, S_LOAD3, S_GO, S_WAIT, S_OUT1, S_OUT2, S_OUT3
`ifdef SWAP_CTRL_TIMEOUT_EN
      , S_ERR
`endif
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   swap_cnt_q;

`ifdef SWAP_CTRL_TIMEOUT_EN
   // Counter holds (WAIT cycles - 1); last WAIT cycle without Done is at TIMEOUT-1
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0] to_cnt_q;
   logic          err_q;

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_q == S_GO)
            to_cnt_q <= '0;
         else if (state_q == S_WAIT && !bus.Done)
            to_cnt_q <= to_cnt_q + CW'(1);
         err_q <= (state_d == S_ERR);
      end
   end

   assign bus.Error = err_q;
`else
   assign bus.Error = 1'b0;
`endif

   // State and completed-swap counter
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q    <= S_LOAD1;
         swap_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_WAIT && bus.Done)
            swap_cnt_q <= swap_cnt_q + CNT_W'(1);
      end
   end

   assign bus.SwapCount = swap_cnt_q;

   // Next state and handshake/datapath decode
   always_comb begin
      state_d      = state_q;
      bus.InReady  = 1'b0;
      bus.Data     = '0;
      bus.RinExt1  = 1'b0;
      bus.RinExt2  = 1'b0;
      bus.RinExt3  = 1'b0;
      bus.w        = 1'b0;
      bus.OutValid = 1'b0;
      bus.OutData  = '0;
      unique case (state_q)
         S_LOAD1: begin
            bus.InReady = 1'b1;
            bus.Data    = bus.InData;
            bus.RinExt1 = bus.InValid;
            if (bus.InValid) state_d = S_LOAD2;
         end
         S_LOAD2: begin
            bus.InReady = 1'b1;
            bus.Data    = bus.InData;
            bus.RinExt2 = bus.InValid;
            if (bus.InValid) state_d = S_LOAD3;
         end
         S_LOAD3: begin
            bus.InReady = 1'b1;
            bus.Data    = bus.InData;
            bus.RinExt3 = bus.InValid;
            if (bus.InValid) state_d = S_GO;
         end
         S_GO: begin
            bus.w   = 1'b1;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.Done)
               state_d = S_OUT1;
`ifdef SWAP_CTRL_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST)
               state_d = S_ERR;
`endif
         end
         S_OUT1: begin
            bus.OutValid = 1'b1;
            bus.OutData  = bus.R1;
            if (bus.OutReady) state_d = S_OUT2;
         end
         S_OUT2: begin
            bus.OutValid = 1'b1;
            bus.OutData  = bus.R2;
            if (bus.OutReady) state_d = S_OUT3;
         end
         S_OUT3: begin
            bus.OutValid = 1'b1;
            bus.OutData  = bus.R3;
            if (bus.OutReady) state_d = S_LOAD1;
         end
`ifdef SWAP_CTRL_TIMEOUT_EN
         S_ERR: state_d = S_ERR;
`endif
         default: state_d = S_LOAD1;
      endcase
   end
endmodule

// File: tb/tb_swap_ctrl.sv
// Directed bench for swap_ctrl with a behavioural swap datapath (R3<=R2, R2<=R1, R1<=R3, Done 3 cycles after w).
// Timeout checks run only when SWAP_CTRL_TIMEOUT_EN is defined.
module tb_swap_ctrl;
   localparam int unsigned TIMEOUT = 15;

   logic       Clock;
   logic       Resetn;
   int         tests = 0;
   int         fails = 0;
   int         cyc_n = 0;
   logic [7:0] exp_cnt;

   logic [7:0] r1, r2, r3;
   logic [1:0] pipe;
   logic       done_dp;
   logic       done_mode;
   logic       done_man;

   swap_ctrl_if #(.n(8)) bus ();

   swap_ctrl #(.n(8), .TIMEOUT(TIMEOUT), .CW(4)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus.master)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc_n <= cyc_n + 1;

   // Swap datapath model
   always @(posedge Clock) begin
      if (!Resetn) begin
         pipe    <= 2'b00;
         done_dp <= 1'b0;
      end else begin
         pipe    <= {pipe[0], bus.w};
         done_dp <= pipe[1];
         if (bus.RinExt1) r1 <= bus.Data;
         if (bus.RinExt2) r2 <= bus.Data;
         if (bus.RinExt3) r3 <= bus.Data;
         if (bus.w)   r3 <= r2;
         if (pipe[0]) r2 <= r1;
         if (pipe[1]) r1 <= r3;
      end
   end

   assign bus.R1   = r1;
   assign bus.R2   = r2;
   assign bus.R3   = r3;
   assign bus.Done = done_mode ? done_man : done_dp;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset();
      Resetn = 1'b0;
      bus.InValid = 1'b0;
      bus.OutReady = 1'b0;
      repeat (2) cyc();
      Resetn = 1'b1;
      exp_cnt = 8'd0;
   endtask

   task automatic load_ops(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      logic [7:0] ops [3];
      ops[0] = a; ops[1] = b; ops[2] = c;
      for (int k = 0; k < 3; k++) begin
         bus.InValid = 1'b1;
         bus.InData  = ops[k];
         cyc();
      end
      bus.InValid = 1'b0;
   endtask

   task automatic run_swap(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input int gaps, input int bp);
      logic [7:0] ops [3];
      int t0, n, nw;
      ops[0] = a; ops[1] = b; ops[2] = c;
      t0 = 0;
      for (int k = 0; k < 3; k++) begin
         for (int g = 0; g < gaps; g++) begin
            bus.InValid = 1'b0;
            bus.InData  = 8'hEE;
            #1;
            chk("gap_strobe", {bus.RinExt1, bus.RinExt2, bus.RinExt3}, 0);
            chk("gap_ready", bus.InReady, 1);
            cyc();
         end
         bus.InValid = 1'b1;
         bus.InData  = ops[k];
         #1;
         chk("load_strobe", {bus.RinExt1, bus.RinExt2, bus.RinExt3}, 3'b100 >> k);
         chk("load_data", bus.Data, ops[k]);
         if (k == 0) t0 = cyc_n;
         cyc();
      end
      bus.InValid = 1'b0;
      #1;
      chk("go_w", bus.w, 1);
      chk("go_data", bus.Data, 0);
      chk("go_ready", bus.InReady, 0);
      cyc();
      n = 0;
      nw = 0;
      while (n < 40) begin
         #1;
         if (bus.OutValid) break;
         nw += int'(bus.w);
         n++;
         cyc();
      end
      chk("wait_cycles", n, 3);
      chk("wait_w", nw, 0);
      bus.OutReady = 1'b1;
      #1;
      chk("out1_valid", bus.OutValid, 1);
      chk("out1_data", bus.OutData, b);
      chk("out1_inready", bus.InReady, 0);
      cyc();
      if (bp > 0) begin
         bus.OutReady = 1'b0;
         bus.InValid  = 1'b1;
         bus.InData   = 8'h99;
         for (int i = 0; i < bp; i++) begin
            #1;
            chk("bp_data", bus.OutData, a);
            chk("bp_valid", bus.OutValid, 1);
            chk("bp_inready", bus.InReady, 0);
            chk("bp_strobe", {bus.RinExt1, bus.RinExt2, bus.RinExt3}, 0);
            cyc();
         end
         bus.OutReady = 1'b1;
         bus.InValid  = 1'b0;
      end
      #1;
      chk("out2_valid", bus.OutValid, 1);
      chk("out2_data", bus.OutData, a);
      cyc();
      #1;
      chk("out3_valid", bus.OutValid, 1);
      chk("out3_data", bus.OutData, b);
      cyc();
      if (gaps == 0 && bp == 0) chk("txn_cycles", cyc_n - t0, 10);
      bus.OutReady = 1'b0;
      #1;
      exp_cnt = exp_cnt + 8'd1;
      chk("idle_inready", bus.InReady, 1);
      chk("idle_outvalid", bus.OutValid, 0);
      chk("swap_count", bus.SwapCount, exp_cnt);
   endtask

   initial begin
      Resetn       = 1'b0;
      bus.InData   = 8'h00;
      bus.InValid  = 1'b0;
      bus.OutReady = 1'b0;
      done_mode    = 1'b0;
      done_man     = 1'b0;
      exp_cnt      = 8'd0;

      // Reset state
      repeat (2) cyc();
      #1;
      chk("rst_inready", bus.InReady, 1);
      chk("rst_outvalid", bus.OutValid, 0);
      chk("rst_w", bus.w, 0);
      chk("rst_count", bus.SwapCount, 0);
      chk("rst_error", bus.Error, 0);
      Resetn = 1'b1;
      cyc();

      // Basic swap, input gaps, output backpressure
      run_swap(8'h11, 8'h22, 8'h33, 0, 0);
      run_swap(8'h11, 8'h22, 8'h33, 2, 0);
      run_swap(8'h11, 8'h22, 8'h33, 0, 5);
      run_swap(8'hA5, 8'h5A, 8'hC3, 0, 0);

      // Reset one cycle after GO abandons the swap
      do_reset();
      load_ops(8'h01, 8'h02, 8'h03);
      cyc();
      Resetn = 1'b0;
      cyc();
      Resetn = 1'b1;
      #1;
      chk("midrst_inready", bus.InReady, 1);
      chk("midrst_outvalid", bus.OutValid, 0);
      chk("midrst_w", bus.w, 0);
      chk("midrst_count", bus.SwapCount, 0);
      repeat (4) cyc();
      chk("midrst_hold_ready", bus.InReady, 1);
      chk("midrst_hold_count", bus.SwapCount, 0);
      run_swap(8'h3C, 8'hC3, 8'h7E, 0, 0);

`ifdef SWAP_CTRL_TIMEOUT_EN
      begin : timeout_test
         int n;
         do_reset();
         done_mode = 1'b1;
         done_man  = 1'b0;
         load_ops(8'h0A, 8'h0B, 8'h0C);
         #1;
         chk("to_go_w", bus.w, 1);
         n = 0;
         while (n < 100) begin
            cyc();
            n++;
            chk("to_handshake", {bus.InReady, bus.OutValid, bus.w}, 0);
            if (bus.Error) break;
         end
         chk("to_latency", n, TIMEOUT + 1);
         bus.InValid  = 1'b1;
         bus.OutReady = 1'b1;
         for (int i = 0; i < 5; i++) begin
            cyc();
            chk("to_sticky", bus.Error, 1);
            chk("to_err_handshake", {bus.InReady, bus.OutValid, bus.w}, 0);
         end
         do_reset();
         #1;
         chk("to_clear_error", bus.Error, 0);
         chk("to_clear_ready", bus.InReady, 1);

         // Done on the limit cycle wins over the timeout
         load_ops(8'h0A, 8'h0B, 8'h0C);
         for (int i = 1; i < int'(TIMEOUT); i++) cyc();
         cyc();
         done_man = 1'b1;
         #1;
         chk("edge_wait_valid", bus.OutValid, 0);
         chk("edge_wait_error", bus.Error, 0);
         cyc();
         done_man = 1'b0;
         chk("edge_out1_valid", bus.OutValid, 1);
         chk("edge_out1_data", bus.OutData, 8'h0B);
         chk("edge_no_error", bus.Error, 0);
         bus.OutReady = 1'b1;
         repeat (3) cyc();
         bus.OutReady = 1'b0;
         #1;
         chk("edge_count", bus.SwapCount, 1);
         chk("edge_idle_ready", bus.InReady, 1);
         done_mode = 1'b0;
      end
`endif

      // 256 back-to-back swaps wrap the counter
      do_reset();
      cyc();
      for (int i = 0; i < 256; i++)
         run_swap(8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
      chk("wrap_count", bus.SwapCount, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
